// File: rtl/xbar_rtn_rob.sv
// Per-channel return reorder buffer: grants rob_nums to accepted requests, absorbs
// out-of-order sc returns and releases data to the channel strictly in allocation order.
module xbar_rtn_rob #(
  parameter int DEPTH  = 8,
  parameter int ID_W   = 3,
  parameter int DATA_W = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alloc_valid_i,
  output logic              alloc_ready_o,
  output logic [ID_W-1:0]   alloc_rob_num_o,
  input  logic              fill_valid_i,
  input  logic [ID_W-1:0]   fill_rob_num_i,
  input  logic [DATA_W-1:0] fill_data_i,
  output logic              fill_err_o,
  output logic              rtn_valid_o,
  input  logic              rtn_ready_i,
  output logic [DATA_W-1:0] rtn_data_o,
  output logic [ID_W:0]     count_o
);

  localparam logic [ID_W:0] FULL_C = (ID_W+1)'(DEPTH);
  localparam logic [ID_W:0] ONE_C  = (ID_W+1)'(1);

  logic [DEPTH-1:0]  busy_r;
  logic [DEPTH-1:0]  done_r;
  logic [DATA_W-1:0] data_r [DEPTH];
  logic [ID_W:0]     alloc_ptr_r;
  logic [ID_W:0]     head_ptr_r;
  logic              fill_err_r;

  logic [ID_W-1:0]   alloc_idx_s;
  logic [ID_W-1:0]   head_idx_s;
  logic [ID_W:0]     count_s;
  logic              alloc_ready_s;
  logic              alloc_fire_s;
  logic              fill_legal_s;
  logic              rtn_valid_s;
  logic              pop_s;
  logic [DATA_W-1:0] rtn_data_s;

  // Occupancy, handshakes and head-of-queue view, all derived from registered state.
  always_comb begin
    alloc_idx_s   = alloc_ptr_r[ID_W-1:0];
    head_idx_s    = head_ptr_r[ID_W-1:0];
    count_s       = alloc_ptr_r - head_ptr_r;
    alloc_ready_s = (count_s != FULL_C);
    alloc_fire_s  = alloc_valid_i & alloc_ready_s;
    fill_legal_s  = busy_r[fill_rob_num_i] & ~done_r[fill_rob_num_i];
    rtn_valid_s   = busy_r[head_idx_s] & done_r[head_idx_s];
    pop_s         = rtn_valid_s & rtn_ready_i;
    if (rtn_valid_s) begin
      rtn_data_s = data_r[head_idx_s];
    end else begin
      rtn_data_s = '0;
    end
  end

  // Entry state and pointers. The allocated entry is FREE, the legally filled one is
  // WAIT and the popped one is READY, so the three updates never hit the same entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_r      <= '0;
      done_r      <= '0;
      alloc_ptr_r <= '0;
      head_ptr_r  <= '0;
      fill_err_r  <= 1'b0;
    end else begin
      fill_err_r <= fill_valid_i & ~fill_legal_s;
      if (alloc_fire_s) begin
        busy_r[alloc_idx_s] <= 1'b1;
        done_r[alloc_idx_s] <= 1'b0;
        alloc_ptr_r         <= alloc_ptr_r + ONE_C;
      end
      if (fill_valid_i && fill_legal_s) begin
        done_r[fill_rob_num_i] <= 1'b1;
      end
      if (pop_s) begin
        busy_r[head_idx_s] <= 1'b0;
        done_r[head_idx_s] <= 1'b0;
        head_ptr_r         <= head_ptr_r + ONE_C;
      end
    end
  end

  // Return data storage; contents are only observable behind done, so no reset.
  always_ff @(posedge clk_i) begin
    if (fill_valid_i && fill_legal_s) begin
      data_r[fill_rob_num_i] <= fill_data_i;
    end
  end

  assign alloc_ready_o   = alloc_ready_s;
  assign alloc_rob_num_o = alloc_idx_s;
  assign fill_err_o      = fill_err_r;
  assign rtn_valid_o     = rtn_valid_s;
  assign rtn_data_o      = rtn_data_s;
  assign count_o         = count_s;

endmodule

// File: tb/tb_xbar_rtn_rob.sv
// Self-checking bench for xbar_rtn_rob: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_xbar_rtn_rob;

  localparam int DEPTH  = 8;
  localparam int ID_W   = 3;
  localparam int DATA_W = 128;

  logic              clk = 1'b0;
  logic              rst;
  logic              alloc_valid;
  logic              alloc_ready;
  logic [ID_W-1:0]   alloc_rob_num;
  logic              fill_valid;
  logic [ID_W-1:0]   fill_rob_num;
  logic [DATA_W-1:0] fill_data;
  logic              fill_err;
  logic              rtn_valid;
  logic              rtn_ready;
  logic [DATA_W-1:0] rtn_data;
  logic [ID_W:0]     count;

  always #5 clk = ~clk;

  xbar_rtn_rob #(.DEPTH(DEPTH), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready), .alloc_rob_num_o(alloc_rob_num),
    .fill_valid_i(fill_valid), .fill_rob_num_i(fill_rob_num), .fill_data_i(fill_data),
    .fill_err_o(fill_err),
    .rtn_valid_o(rtn_valid), .rtn_ready_i(rtn_ready), .rtn_data_o(rtn_data),
    .count_o(count)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: state per rob_num (0 FREE, 1 WAIT, 2 READY), allocation-order queue.
  int                m_st [DEPTH];
  logic [DATA_W-1:0] m_data [DEPTH];
  int                m_q [$];
  int                m_next;
  bit                m_err;

  task automatic chk(string nm, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update(bit r, bit a, bit f, int fid, logic [DATA_W-1:0] fd, bit rr);
    bit fire, pop, legal;
    if (r) begin
      for (int i = 0; i < DEPTH; i++) m_st[i] = 0;
      m_q.delete();
      m_next = 0;
      m_err  = 1'b0;
    end else begin
      fire  = a && (m_q.size() < DEPTH);
      pop   = rr && (m_q.size() > 0) && (m_st[m_q[0]] == 2);
      legal = f && (m_st[fid] == 1);
      m_err = f && !legal;
      if (legal) begin
        m_st[fid]   = 2;
        m_data[fid] = fd;
      end
      if (pop) begin
        m_st[m_q[0]] = 0;
        void'(m_q.pop_front());
      end
      if (fire) begin
        m_st[m_next] = 1;
        m_q.push_back(m_next);
        m_next = (m_next + 1) % DEPTH;
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model, then settle past the edge.
  task automatic step(bit r, bit a, bit f, int fid, logic [DATA_W-1:0] fd, bit rr);
    logic [31:0] fid_v;
    fid_v        = fid;
    rst          = r;
    alloc_valid  = a;
    fill_valid   = f;
    fill_rob_num = fid_v[ID_W-1:0];
    fill_data    = fd;
    rtn_ready    = rr;
    @(posedge clk);
    model_update(r, a, f, fid, fd, rr);
    #1;
  endtask

  task automatic idle(bit rr);
    step(1'b0, 1'b0, 1'b0, 0, '0, rr);
  endtask

  task automatic check_model();
    bit vld;
    vld = (m_q.size() > 0) && (m_st[m_q[0]] == 2);
    chk("m_ready", alloc_ready, m_q.size() < DEPTH);
    chk("m_rob",   alloc_rob_num, m_next);
    chk("m_count", count, m_q.size());
    chk("m_err",   fill_err, m_err);
    chk("m_valid", rtn_valid, vld);
    chk("m_data",  rtn_data, vld ? m_data[m_q[0]] : '0);
  endtask

  typedef struct {
    bit r; bit a; bit f; int fid; logic [DATA_W-1:0] fd; bit rr;
    bit e_rdy; int e_rob; bit e_val; logic [DATA_W-1:0] e_data; bit e_err; int e_cnt;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int ord [4];
    int tmp, k, base, fid;
    logic [DATA_W-1:0] d;

    // In-order traffic then one illegal fill; expectations observed just after each edge.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 0, 128'h0,  1'b0, 1'b1, 0, 1'b0, 128'h0,  1'b0, 0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 0, 128'h0,  1'b0, 1'b1, 1, 1'b0, 128'h0,  1'b0, 1};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 0, 128'h0,  1'b0, 1'b1, 2, 1'b0, 128'h0,  1'b0, 2};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 0, 128'h0,  1'b0, 1'b1, 3, 1'b0, 128'h0,  1'b0, 3};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 0, 128'hA0, 1'b1, 1'b1, 3, 1'b1, 128'hA0, 1'b0, 3};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1, 128'hA1, 1'b1, 1'b1, 3, 1'b1, 128'hA1, 1'b0, 2};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 2, 128'hA2, 1'b1, 1'b1, 3, 1'b1, 128'hA2, 1'b0, 1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 0, 128'h0,  1'b1, 1'b1, 3, 1'b0, 128'h0,  1'b0, 0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 5, 128'h55, 1'b0, 1'b1, 3, 1'b0, 128'h0,  1'b1, 0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 0, 128'h0,  1'b0, 1'b1, 3, 1'b0, 128'h0,  1'b0, 0};

    rst = 1'b1; alloc_valid = 1'b0; fill_valid = 1'b0; fill_rob_num = '0;
    fill_data = '0; rtn_ready = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].r, tbl[i].a, tbl[i].f, tbl[i].fid, tbl[i].fd, tbl[i].rr);
      chk("tbl_ready", alloc_ready, tbl[i].e_rdy);
      chk("tbl_rob",   alloc_rob_num, tbl[i].e_rob);
      chk("tbl_valid", rtn_valid, tbl[i].e_val);
      chk("tbl_data",  rtn_data, tbl[i].e_data);
      chk("tbl_err",   fill_err, tbl[i].e_err);
      chk("tbl_count", count, tbl[i].e_cnt);
    end

    // Reorder: fills 3,2,1 leave head empty; fill 0 releases rob 0 one cycle later.
    step(1'b1, 1'b0, 1'b0, 0, '0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 0, '0, 1'b0);
    for (int i = 3; i >= 1; i--) begin
      step(1'b0, 1'b0, 1'b1, i, 128'hD0 + i, 1'b1);
      chk("reo_hold_valid", rtn_valid, 1'b0);
    end
    step(1'b0, 1'b0, 1'b1, 0, 128'hD0, 1'b0);
    chk("reo_valid", rtn_valid, 1'b1);
    chk("reo_d0", rtn_data, 128'hD0);
    for (int i = 1; i < 4; i++) begin
      idle(1'b1);
      chk("reo_data", rtn_data, 128'hD0 + i);
    end
    idle(1'b1);
    chk("reo_empty", rtn_valid, 1'b0);
    chk("reo_count", count, 0);

    // Full and backpressure.
    step(1'b1, 1'b0, 1'b0, 0, '0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 0, '0, 1'b0);
    chk("full_ready", alloc_ready, 1'b0);
    chk("full_count", count, 8);
    step(1'b0, 1'b1, 1'b0, 0, '0, 1'b0);
    chk("full_noalloc", count, 8);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, i, 128'h100 + i, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      chk("bp_valid", rtn_valid, 1'b1);
      chk("bp_data", rtn_data, 128'h100);
    end
    step(1'b0, 1'b1, 1'b0, 0, '0, 1'b1);
    chk("pop_ready", alloc_ready, 1'b1);
    chk("pop_count", count, 7);
    chk("pop_data", rtn_data, 128'h101);
    chk("pop_rob", alloc_rob_num, 0);
    step(1'b0, 1'b1, 1'b0, 0, '0, 1'b0);
    chk("refill_count", count, 8);
    chk("refill_ready", alloc_ready, 1'b0);
    check_model();

    // Illegal fills: FREE entry and double fill; the first data survives.
    step(1'b1, 1'b0, 1'b0, 0, '0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 0, 128'h11, 1'b0);
    chk("ill_first_err", fill_err, 1'b0);
    step(1'b0, 1'b0, 1'b1, 0, 128'h22, 1'b0);
    chk("ill_dup_err", fill_err, 1'b1);
    idle(1'b0);
    chk("ill_pulse", fill_err, 1'b0);
    chk("ill_keep", rtn_data, 128'h11);
    step(1'b0, 1'b0, 1'b1, 5, 128'h33, 1'b0);
    chk("ill_free_err", fill_err, 1'b1);
    idle(1'b0);
    chk("ill_free_pulse", fill_err, 1'b0);

    // Reset mid-flight.
    step(1'b1, 1'b0, 1'b0, 0, '0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 0, 128'hE0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1, 128'hE1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, '0, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_valid", rtn_valid, 1'b0);
    chk("rst_rob", alloc_rob_num, 0);
    chk("rst_data", rtn_data, 128'h0);
    chk("rst_ready", alloc_ready, 1'b1);
    step(1'b0, 1'b0, 1'b1, 2, 128'hE2, 1'b0);
    chk("rst_stale_err", fill_err, 1'b1);

    // Wrap: 5 rounds of 4 allocs, shuffled fills, in-order pops (rob 0..7,0..7,0..3).
    step(1'b1, 1'b0, 1'b0, 0, '0, 1'b0);
    for (int rd = 0; rd < 5; rd++) begin
      for (int j = 0; j < 4; j++) begin
        k = 4 * rd + j;
        chk("wrap_rob", alloc_rob_num, k % 8);
        step(1'b0, 1'b1, 1'b0, 0, '0, 1'b0);
      end
      base = (4 * rd) % 8;
      for (int j = 0; j < 4; j++) ord[j] = base + j;
      for (int j = 3; j > 0; j--) begin
        k = $urandom_range(0, j);
        tmp = ord[j]; ord[j] = ord[k]; ord[k] = tmp;
      end
      for (int j = 0; j < 4; j++) begin
        step(1'b0, 1'b0, 1'b1, ord[j], 128'hC000 + 4 * rd + (ord[j] - base), 1'b0);
        chk("wrap_err", fill_err, 1'b0);
      end
      for (int j = 0; j < 4; j++) begin
        chk("wrap_data", rtn_data, 128'hC000 + 4 * rd + j);
        idle(1'b1);
      end
      chk("wrap_count", count, 0);
    end

    // Randomized traffic against the model.
    step(1'b1, 1'b0, 1'b0, 0, '0, 1'b0);
    check_model();
    for (int c = 0; c < 400; c++) begin
      if (m_q.size() > 0 && $urandom_range(0, 3) != 0)
        fid = m_q[$urandom_range(0, m_q.size() - 1)];
      else
        fid = $urandom_range(0, DEPTH - 1);
      d = {$urandom, $urandom, $urandom, $urandom};
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 2) != 0), fid, d, ($urandom_range(0, 3) != 0));
      check_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
